// File: rtl/fft8_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : fft8_pkg
// Purpose  : Shared constants, FSM states and helpers for the 8-point FFT.
// Revision : 1.0  initial release
// ============================================================================
package fft8_pkg;

   localparam int DATA_W = 16;
   localparam int N      = 8;

   // Q1.15 twiddles; W0 and W2 are handled exactly inside the butterfly
   localparam logic signed [DATA_W-1:0] W1_RE =  16'sd23170;
   localparam logic signed [DATA_W-1:0] W1_IM = -16'sd23170;
   localparam logic signed [DATA_W-1:0] W3_RE = -16'sd23170;
   localparam logic signed [DATA_W-1:0] W3_IM = -16'sd23170;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_S1   = 3'd2,
      ST_S2   = 3'd3,
      ST_S3   = 3'd4,
      ST_DONE = 3'd5
   } state_e;

   function automatic logic [2:0] bitrev3(input logic [2:0] n);
      return {n[0], n[1], n[2]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/fft_radix2_bfly.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : fft_radix2_bfly
// Purpose  : Combinational radix-2 DIT butterfly with 1/2 scaling per stage.
// Revision : 1.0  initial release
// ============================================================================
module fft_radix2_bfly
   import fft8_pkg::*;
(
   input  logic signed [DATA_W-1:0] a_re_i,
   input  logic signed [DATA_W-1:0] a_im_i,
   input  logic signed [DATA_W-1:0] b_re_i,
   input  logic signed [DATA_W-1:0] b_im_i,
   input  logic        [1:0]        tw_sel_i,
   output logic signed [DATA_W-1:0] a_re_o,
   output logic signed [DATA_W-1:0] a_im_o,
   output logic signed [DATA_W-1:0] b_re_o,
   output logic signed [DATA_W-1:0] b_im_o
);

   localparam logic signed [DATA_W-1:0] C_MIN = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic signed [DATA_W:0]   C_MAX = (DATA_W+1)'(2**(DATA_W-1) - 1);

   logic signed [DATA_W-1:0]   w_re, w_im;
   logic signed [2*DATA_W-1:0] p_rr, p_ii, p_ri, p_ir;
   logic signed [DATA_W:0]     t_re, t_im;
   logic signed [DATA_W+1:0]   a_re_x, a_im_x, t_re_x, t_im_x;

   always_comb begin
      w_re = W1_RE;
      w_im = W1_IM;
      if (tw_sel_i == 2'd3) begin
         w_re = W3_RE;
         w_im = W3_IM;
      end
      p_rr = (2*DATA_W)'(b_re_i) * (2*DATA_W)'(w_re);
      p_ii = (2*DATA_W)'(b_im_i) * (2*DATA_W)'(w_im);
      p_ri = (2*DATA_W)'(b_re_i) * (2*DATA_W)'(w_im);
      p_ir = (2*DATA_W)'(b_im_i) * (2*DATA_W)'(w_re);

      // t is kept one bit wider than a sample so a rotated full-scale value cannot wrap
      case (tw_sel_i)
         2'd0: begin
            t_re = (DATA_W+1)'(b_re_i);
            t_im = (DATA_W+1)'(b_im_i);
         end
         2'd2: begin
            t_re = (DATA_W+1)'(b_im_i);
            t_im = (b_re_i == C_MIN) ? C_MAX : -(DATA_W+1)'(b_re_i);
         end
         default: begin
            t_re = (DATA_W+1)'((p_rr - p_ii) >>> (DATA_W-1));
            t_im = (DATA_W+1)'((p_ri + p_ir) >>> (DATA_W-1));
         end
      endcase

      a_re_x = (DATA_W+2)'(a_re_i);
      a_im_x = (DATA_W+2)'(a_im_i);
      t_re_x = (DATA_W+2)'(t_re);
      t_im_x = (DATA_W+2)'(t_im);
      a_re_o = DATA_W'((a_re_x + t_re_x) >>> 1);
      a_im_o = DATA_W'((a_im_x + t_im_x) >>> 1);
      b_re_o = DATA_W'((a_re_x - t_re_x) >>> 1);
      b_im_o = DATA_W'((a_im_x - t_im_x) >>> 1);
   end

endmodule
`default_nettype wire

// File: rtl/fft_8_sol1_gen2.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : fft_8_sol1_gen2
// Purpose  : Iterative 8-point radix-2 DIT FFT, one butterfly stage per clock.
// Revision : 1.0  initial release
// ============================================================================
module fft_8_sol1_gen2
   import fft8_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic signed [DATA_W-1:0] data_in_real  [N-1:0],
   input  logic signed [DATA_W-1:0] data_in_imag  [N-1:0],
   output logic signed [DATA_W-1:0] data_out_real [N-1:0],
   output logic signed [DATA_W-1:0] data_out_imag [N-1:0],
   output logic                     done
);

   localparam int NB = N / 2;

   state_e                   state_q;
   logic signed [DATA_W-1:0] work_re_q [N-1:0];
   logic signed [DATA_W-1:0] work_im_q [N-1:0];

   logic        [2:0]        idx_a  [NB-1:0];
   logic        [2:0]        idx_b  [NB-1:0];
   logic        [1:0]        tw_sel [NB-1:0];
   logic signed [DATA_W-1:0] bf_a_re [NB-1:0], bf_a_im [NB-1:0];
   logic signed [DATA_W-1:0] bf_b_re [NB-1:0], bf_b_im [NB-1:0];
   logic signed [DATA_W-1:0] bf_a_re_n [NB-1:0], bf_a_im_n [NB-1:0];
   logic signed [DATA_W-1:0] bf_b_re_n [NB-1:0], bf_b_im_n [NB-1:0];

   // Pair (i, i+span) and twiddle exponent k for butterfly j in the current stage
   always_comb begin
      for (int j = 0; j < NB; j++) begin
         idx_a[j]  = 3'(2*j);
         idx_b[j]  = 3'(2*j + 1);
         tw_sel[j] = 2'd0;
         if (state_q == ST_S2) begin
            idx_a[j]  = 3'((j/2)*4 + j%2);
            idx_b[j]  = 3'((j/2)*4 + j%2 + 2);
            tw_sel[j] = 2'((j%2)*2);
         end else if (state_q == ST_S3) begin
            idx_a[j]  = 3'(j);
            idx_b[j]  = 3'(j + 4);
            tw_sel[j] = 2'(j);
         end
         bf_a_re[j] = work_re_q[idx_a[j]];
         bf_a_im[j] = work_im_q[idx_a[j]];
         bf_b_re[j] = work_re_q[idx_b[j]];
         bf_b_im[j] = work_im_q[idx_b[j]];
      end
   end

   generate
      for (genvar j = 0; j < NB; j++) begin : g_bfly
         fft_radix2_bfly u_bfly (
            .a_re_i   (bf_a_re[j]),
            .a_im_i   (bf_a_im[j]),
            .b_re_i   (bf_b_re[j]),
            .b_im_i   (bf_b_im[j]),
            .tw_sel_i (tw_sel[j]),
            .a_re_o   (bf_a_re_n[j]),
            .a_im_o   (bf_a_im_n[j]),
            .b_re_o   (bf_b_re_n[j]),
            .b_im_o   (bf_b_im_n[j])
         );
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         done    <= 1'b0;
         for (int n = 0; n < N; n++) begin
            work_re_q[n]     <= '0;
            work_im_q[n]     <= '0;
            data_out_real[n] <= '0;
            data_out_imag[n] <= '0;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) state_q <= ST_LOAD;
            end
            ST_LOAD: begin
               for (int n = 0; n < N; n++) begin
                  work_re_q[bitrev3(3'(n))] <= data_in_real[n];
                  work_im_q[bitrev3(3'(n))] <= data_in_imag[n];
               end
               state_q <= ST_S1;
            end
            ST_S1, ST_S2, ST_S3: begin
               for (int j = 0; j < NB; j++) begin
                  work_re_q[idx_a[j]] <= bf_a_re_n[j];
                  work_im_q[idx_a[j]] <= bf_a_im_n[j];
                  work_re_q[idx_b[j]] <= bf_b_re_n[j];
                  work_im_q[idx_b[j]] <= bf_b_im_n[j];
               end
               if (state_q == ST_S1) begin
                  state_q <= ST_S2;
               end else if (state_q == ST_S2) begin
                  state_q <= ST_S3;
               end else begin
                  // Final stage results go straight to the output registers
                  for (int j = 0; j < NB; j++) begin
                     data_out_real[idx_a[j]] <= bf_a_re_n[j];
                     data_out_imag[idx_a[j]] <= bf_a_im_n[j];
                     data_out_real[idx_b[j]] <= bf_b_re_n[j];
                     data_out_imag[idx_b[j]] <= bf_b_im_n[j];
                  end
                  done    <= 1'b1;
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (start) begin
                  done    <= 1'b0;
                  state_q <= ST_LOAD;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fft_8_sol1_gen2.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_fft_8_sol1_gen2
// Purpose  : Scoreboard bench comparing the FFT against a floating-point DFT/8.
// Revision : 1.0  initial release
// ============================================================================
module tb_fft_8_sol1_gen2;
   import fft8_pkg::*;

   typedef struct packed {
      logic [7:0][15:0] re;
      logic [7:0][15:0] im;
      logic [3:0]       tol;
   } exp_t;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     start;
   logic signed [DATA_W-1:0] din_re  [N-1:0];
   logic signed [DATA_W-1:0] din_im  [N-1:0];
   logic signed [DATA_W-1:0] dout_re [N-1:0];
   logic signed [DATA_W-1:0] dout_im [N-1:0];
   logic                     done;

   exp_t sb_q[$];
   exp_t last_exp;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic done_d   = 1'b0;

   always #5 clk = ~clk;

   fft_8_sol1_gen2 dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .data_in_real  (din_re),
      .data_in_imag  (din_im),
      .data_out_real (dout_re),
      .data_out_imag (dout_im),
      .done          (done)
   );

   task automatic check_val(input string tag, input int got, input int exp, input int tol);
      n_checks++;
      if (got - exp > tol || exp - got > tol) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
      end
   endtask

   function automatic int rnd(input real v);
      return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
   endfunction

   function automatic exp_t dft_model(input int xr[8], input int xi[8], input int tol);
      exp_t e;
      real  sr, si, th;
      e.tol = 4'(tol);
      for (int k = 0; k < 8; k++) begin
         sr = 0.0;
         si = 0.0;
         for (int n = 0; n < 8; n++) begin
            th = 2.0 * 3.14159265358979 * real'(k * n) / 8.0;
            sr = sr + real'(xr[n]) * $cos(th) + real'(xi[n]) * $sin(th);
            si = si + real'(xi[n]) * $cos(th) - real'(xr[n]) * $sin(th);
         end
         e.re[k] = 16'(rnd(sr / 8.0));
         e.im[k] = 16'(rnd(si / 8.0));
      end
      return e;
   endfunction

   // Scoreboard consumer: compare on each rising edge of done
   always @(negedge clk) begin
      exp_t e;
      if (done && !done_d) begin
         if (sb_q.size() == 0) begin
            check_val("unexpected_done", 1, 0, 0);
         end else begin
            e = sb_q.pop_front();
            last_exp = e;
            for (int k = 0; k < 8; k++) begin
               check_val($sformatf("X%0d_re", k), int'(dout_re[k]), int'($signed(e.re[k])), int'(e.tol));
               check_val($sformatf("X%0d_im", k), int'(dout_im[k]), int'($signed(e.im[k])), int'(e.tol));
            end
         end
      end
      done_d = done;
   end

   task automatic drive_inputs(input int xr[8], input int xi[8], input int tol);
      for (int n = 0; n < 8; n++) begin
         din_re[n] = 16'(xr[n]);
         din_im[n] = 16'(xi[n]);
      end
      sb_q.push_back(dft_model(xr, xi, tol));
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   // elapsed = negedges already seen since the start edge
   task automatic wait_done(input int elapsed);
      int lat   = elapsed;
      int found = 0;
      if (done) found = 1;
      while (!found && lat < 12) begin
         @(negedge clk);
         lat++;
         if (done) found = 1;
      end
      check_val("done_timeout", found, 1, 0);
      check_val("done_not_early", (lat >= 4) ? 1 : 0, 1, 0);
   endtask

   task automatic run_frame(input int xr[8], input int xi[8], input int tol);
      drive_inputs(xr, xi, tol);
      pulse_start();
      wait_done(1);
   endtask

   initial begin
      int xr[8], xi[8], z[8];
      z     = '{default: 0};
      rst   = 1'b1;
      start = 1'b1;
      for (int n = 0; n < 8; n++) begin
         din_re[n] = '0;
         din_im[n] = '0;
      end
      repeat (2) @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check_val("rst_done", int'(done), 0, 0);
      for (int k = 0; k < 8; k++) begin
         check_val($sformatf("rst_re%0d", k), int'(dout_re[k]), 0, 0);
         check_val($sformatf("rst_im%0d", k), int'(dout_im[k]), 0, 0);
      end
      repeat (6) @(negedge clk);
      check_val("start_in_rst_ignored", int'(done), 0, 0);

      // Impulse
      xr = z; xr[0] = 16384;
      run_frame(xr, z, 0);
      // DC
      xr = '{default: 4096};
      run_frame(xr, z, 1);
      // Alternating sign
      for (int n = 0; n < 8; n++) xr[n] = (n % 2 == 0) ? 8192 : -8192;
      run_frame(xr, z, 1);
      // Same vector on real and imaginary buses
      xr = z; xr[0] = 16384;
      run_frame(xr, xr, 0);
      // Cosine in bin 1
      xr = '{16384, 11585, 0, -11585, -16384, -11585, 0, 11585};
      run_frame(xr, z, 2);
      // Random moderate-amplitude frame
      for (int n = 0; n < 8; n++) begin
         xr[n] = int'($urandom_range(0, 16383)) - 8192;
         xi[n] = int'($urandom_range(0, 16383)) - 8192;
      end
      run_frame(xr, xi, 3);

      // start during the transform must not restart or add a frame
      xr = z; xr[0] = 16384; xr[1] = 8192;
      drive_inputs(xr, z, 1);
      pulse_start();
      pulse_start();
      wait_done(3);
      repeat (3) begin
         @(negedge clk);
         check_val("hold_done", int'(done), 1, 0);
      end
      check_val("no_extra_frame", sb_q.size(), 0, 0);

      // Back-to-back start from DONE: old result held until overwritten
      xr = '{16384, 11585, 0, -11585, -16384, -11585, 0, 11585};
      xi = '{0, 3000, -3000, 1000, 0, -2000, 4000, 500};
      drive_inputs(xr, xi, 2);
      pulse_start();
      check_val("done_cleared", int'(done), 0, 0);
      check_val("old_X1_held", int'(dout_re[1]), int'($signed(last_exp.re[1])), int'(last_exp.tol));
      wait_done(1);

      // Reset during S2 discards the frame
      xr = z; xr[2] = -12000; xi = z; xi[5] = 7000;
      drive_inputs(xr, xi, 1);
      pulse_start();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      sb_q.delete();
      check_val("midrst_done", int'(done), 0, 0);
      for (int k = 0; k < 8; k++) begin
         check_val($sformatf("midrst_re%0d", k), int'(dout_re[k]), 0, 0);
         check_val($sformatf("midrst_im%0d", k), int'(dout_im[k]), 0, 0);
      end
      @(negedge clk) rst = 1'b0;
      repeat (8) @(negedge clk);
      check_val("midrst_no_done", int'(done), 0, 0);
      run_frame(xr, xi, 1);

      @(negedge clk);
      check_val("sb_empty", sb_q.size(), 0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire
